mem_stage: RTL and testbench

- Fourth stage (MEM) of the 5-stage pipeline. Sits between the EX/MEM register and the WB stage.
- Performs data-memory loads and stores over a request/ready handshake to the data memory. Supports byte, half and word sizes, with sign or zero extension on loads.
- Stalls upstream stages while the memory is busy.
- Owns the MEM/WB pipeline register that feeds WB's memoriaSaida/aluSaida/controle inputs.

---
 rtl/mem_stage.sv | 199 +++++++++++++++++++
 tb/tb_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage. Performs data-memory loads/stores over a
//            request/ready handshake, stalls upstream while the memory is
//            busy, and owns the MEM/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int LIMITE_ESPERA = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] aluResultado,
    input  logic [31:0] dadoEscrita,
    input  logic [4:0]  regDestino,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memToReg,
    input  logic        regWrite,
    input  logic [1:0]  tamanho,
    input  logic        semSinal,
    output logic [31:0] memEndereco,
    output logic [31:0] memDadoEscrita,
    output logic [3:0]  memByteEnable,
    output logic        memReq,
    output logic        memWe,
    input  logic [31:0] memDadoLeitura,
    input  logic        memPronto,
    output logic        stall,
    output logic [31:0] memoriaSaida,
    output logic [31:0] aluSaida,
    output logic        controle,
    output logic        regWriteSaida,
    output logic [4:0]  regDestinoSaida,
    output logic        excecaoAlinhamento,
    output logic        excecaoTimeout
);

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    // Wait counter value on the last ESPERA cycle before the access is aborted
    localparam logic [7:0] LIMITE_FINAL = 8'(LIMITE_ESPERA - 1);

    estado_t     estado;
    estado_t     proximo;
    logic [7:0]  contador;

    logic        acesso;
    logic        desalinhado;
    logic [1:0]  deslocamento;
    logic [3:0]  lanes;
    logic [31:0] dado_replicado;
    logic [7:0]  byte_lido;
    logic [15:0] meia_lida;
    logic [31:0] carga;

    logic        pedido;
    logic        parado;
    logic        concluido;
    logic        estouro;

    assign deslocamento = aluResultado[1:0];
    assign acesso       = memRead | memWrite;
    // Only real accesses can be misaligned; tamanho[1] covers both word codes
    assign desalinhado  = acesso & (((tamanho == 2'b01) & deslocamento[0]) |
                                    (tamanho[1] & (deslocamento != 2'b00)));

    // Store lane selection and data replication
    always_comb begin
        lanes          = 4'b1111;
        dado_replicado = dadoEscrita;
        case (tamanho)
            2'b00: begin
                lanes          = 4'b0001 << deslocamento;
                dado_replicado = {4{dadoEscrita[7:0]}};
            end
            2'b01: begin
                lanes          = deslocamento[1] ? 4'b1100 : 4'b0011;
                dado_replicado = {2{dadoEscrita[15:0]}};
            end
            default: begin
                lanes          = 4'b1111;
                dado_replicado = dadoEscrita;
            end
        endcase
    end

    // Load lane extraction (little-endian) and sign/zero extension
    always_comb begin
        byte_lido = memDadoLeitura[7:0];
        case (deslocamento)
            2'b00:   byte_lido = memDadoLeitura[7:0];
            2'b01:   byte_lido = memDadoLeitura[15:8];
            2'b10:   byte_lido = memDadoLeitura[23:16];
            default: byte_lido = memDadoLeitura[31:24];
        endcase
        meia_lida = deslocamento[1] ? memDadoLeitura[31:16] : memDadoLeitura[15:0];
        case (tamanho)
            2'b00:   carga = semSinal ? {24'b0, byte_lido} : {{24{byte_lido[7]}}, byte_lido};
            2'b01:   carga = semSinal ? {16'b0, meia_lida} : {{16{meia_lida[15]}}, meia_lida};
            default: carga = memDadoLeitura;
        endcase
    end

    // Handshake FSM next-state and control decode
    always_comb begin
        proximo   = estado;
        pedido    = 1'b0;
        parado    = 1'b0;
        concluido = 1'b0;
        estouro   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (acesso && !desalinhado) begin
                    pedido = 1'b1;
                    if (memPronto) begin
                        concluido = 1'b1;
                    end else begin
                        parado  = 1'b1;
                        proximo = ESPERA;
                    end
                end
            end
            ESPERA: begin
                // Request stays up through the limit cycle so a late
                // memPronto there still counts as a normal completion.
                pedido = 1'b1;
                if (memPronto) begin
                    concluido = 1'b1;
                    proximo   = OCIOSO;
                end else if (contador == LIMITE_FINAL) begin
                    estouro = 1'b1;
                    proximo = OCIOSO;
                end else begin
                    parado = 1'b1;
                end
            end
            default: proximo = OCIOSO;
        endcase
    end

    // Memory-side outputs; reset masks them immediately, not at the next edge
    assign memReq         = pedido & reset;
    assign stall          = parado & reset;
    assign memWe          = memReq & memWrite;
    assign memByteEnable  = (memReq & memWrite) ? lanes : 4'b0000;
    assign memEndereco    = {aluResultado[31:2], 2'b00};
    assign memDadoEscrita = dado_replicado;

    // State register and wait counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            contador <= 8'd0;
        end else begin
            estado <= proximo;
            if (estado == ESPERA && proximo == ESPERA) begin
                contador <= contador + 8'd1;
            end else begin
                contador <= 8'd0;
            end
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture this cycle's result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            memoriaSaida       <= 32'd0;
            aluSaida           <= 32'd0;
            controle           <= 1'b0;
            regWriteSaida      <= 1'b0;
            regDestinoSaida    <= 5'd0;
            excecaoAlinhamento <= 1'b0;
            excecaoTimeout     <= 1'b0;
        end else if (parado) begin
            memoriaSaida       <= 32'd0;
            aluSaida           <= 32'd0;
            controle           <= 1'b0;
            regWriteSaida      <= 1'b0;
            regDestinoSaida    <= 5'd0;
            excecaoAlinhamento <= 1'b0;
            excecaoTimeout     <= 1'b0;
        end else begin
            memoriaSaida       <= (concluido && memRead && !memWrite) ? carga : 32'd0;
            aluSaida           <= aluResultado;
            controle           <= memToReg;
            regWriteSaida      <= regWrite & ~desalinhado & ~estouro;
            regDestinoSaida    <= regDestino;
            excecaoAlinhamento <= desalinhado;
            excecaoTimeout     <= estouro;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed testbench for mem_stage: vector table of zero-wait
//            accesses plus hand-written wait, timeout and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic [31:0] aluResultado;
    logic [31:0] dadoEscrita;
    logic [4:0]  regDestino;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        regWrite;
    logic [1:0]  tamanho;
    logic        semSinal;
    logic [31:0] memEndereco;
    logic [31:0] memDadoEscrita;
    logic [3:0]  memByteEnable;
    logic        memReq;
    logic        memWe;
    logic [31:0] memDadoLeitura;
    logic        memPronto;
    logic        stall;
    logic [31:0] memoriaSaida;
    logic [31:0] aluSaida;
    logic        controle;
    logic        regWriteSaida;
    logic [4:0]  regDestinoSaida;
    logic        excecaoAlinhamento;
    logic        excecaoTimeout;

    int checks;
    int failures;

    mem_stage #(.LIMITE_ESPERA(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .aluResultado       (aluResultado),
        .dadoEscrita        (dadoEscrita),
        .regDestino         (regDestino),
        .memRead            (memRead),
        .memWrite           (memWrite),
        .memToReg           (memToReg),
        .regWrite           (regWrite),
        .tamanho            (tamanho),
        .semSinal           (semSinal),
        .memEndereco        (memEndereco),
        .memDadoEscrita     (memDadoEscrita),
        .memByteEnable      (memByteEnable),
        .memReq             (memReq),
        .memWe              (memWe),
        .memDadoLeitura     (memDadoLeitura),
        .memPronto          (memPronto),
        .stall              (stall),
        .memoriaSaida       (memoriaSaida),
        .aluSaida           (aluSaida),
        .controle           (controle),
        .regWriteSaida      (regWriteSaida),
        .regDestinoSaida    (regDestinoSaida),
        .excecaoAlinhamento (excecaoAlinhamento),
        .excecaoTimeout     (excecaoTimeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rd_en;
        logic        wr_en;
        logic        m2r;
        logic        rw;
        logic [1:0]  tam;
        logic        sem;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_dw;
        logic [31:0] e_mo;
        logic        e_rw;
        logic        e_alin;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vt [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Load access that waits; memPronto rises on cycle pronto_at (-1 = never)
    task automatic run_wait(input string nm, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [1:0] tam,
                            input logic sem, input int pronto_at,
                            input int exp_stalls, input logic [31:0] exp_mo,
                            input logic exp_to);
        int  stalls;
        bit  done;
        stalls = 0;
        done   = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clock);
            aluResultado   = addr;
            dadoEscrita    = 32'd0;
            memDadoLeitura = rdata;
            regDestino     = 5'd5;
            memRead        = 1'b1;
            memWrite       = 1'b0;
            memToReg       = 1'b1;
            regWrite       = 1'b1;
            tamanho        = tam;
            semSinal       = sem;
            memPronto      = (k == pronto_at);
            #1;
            chk($sformatf("%s_req_c%0d", nm, k), memReq, 1'b1);
            if (!stall) done = 1;
            else stalls++;
            @(posedge clock);
            #1;
            if (!done) chk($sformatf("%s_bubble_c%0d", nm, k), regWriteSaida, 1'b0);
        end
        if (!done) chk({nm, "_bound"}, 32'd0, 32'd1);
        chk({nm, "_stalls"}, stalls, exp_stalls);
        chk({nm, "_mo"}, memoriaSaida, exp_mo);
        chk({nm, "_rw"}, regWriteSaida, !exp_to);
        chk({nm, "_to"}, excecaoTimeout, exp_to);
        chk({nm, "_ctrl"}, controle, 1'b1);
        // Idle cycle afterwards: exception flag must clear
        @(negedge clock);
        memRead   = 1'b0;
        memPronto = 1'b0;
        regWrite  = 1'b0;
        #1;
        chk({nm, "_idle_req"}, memReq, 1'b0);
        @(posedge clock);
        #1;
        chk({nm, "_idle_to"}, excecaoTimeout, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            addr        wdata       rdata       rd  R  W  M2R RW tam  sem  req we be      dw          mo          rw alin
        vt[0]  = '{32'h00001004, 32'h0,        32'hDEADBEEF, 5'd8,  1, 0, 1, 1, 2'b10, 0, 1, 0, 4'h0, 32'h0,        32'hDEADBEEF, 1, 0};
        vt[1]  = '{32'h0000300A, 32'h0000ABCD, 32'h0,        5'd0,  0, 1, 0, 0, 2'b01, 0, 1, 1, 4'hC, 32'hABCDABCD, 32'h0,        0, 0};
        vt[2]  = '{32'h00003001, 32'h12345678, 32'h0,        5'd0,  0, 1, 0, 0, 2'b00, 0, 1, 1, 4'h2, 32'h78787878, 32'h0,        0, 0};
        vt[3]  = '{32'h00004002, 32'h0,        32'h11111111, 5'd9,  1, 0, 1, 1, 2'b10, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1};
        vt[4]  = '{32'h00004001, 32'h0,        32'h22222222, 5'd10, 1, 0, 1, 1, 2'b01, 0, 0, 0, 4'h0, 32'h0,        32'h0,        0, 1};
        vt[5]  = '{32'h00002002, 32'h0,        32'h80FF1234, 5'd3,  1, 0, 1, 1, 2'b01, 1, 1, 0, 4'h0, 32'h0,        32'h000080FF, 1, 0};
        vt[6]  = '{32'h00002002, 32'h0,        32'h80FF1234, 5'd3,  1, 0, 1, 1, 2'b01, 0, 1, 0, 4'h0, 32'h0,        32'hFFFF80FF, 1, 0};
        vt[7]  = '{32'h00002000, 32'h0,        32'h80FF1234, 5'd4,  1, 0, 1, 1, 2'b01, 0, 1, 0, 4'h0, 32'h0,        32'h00001234, 1, 0};
        vt[8]  = '{32'h00002001, 32'h0,        32'h80FF1234, 5'd6,  1, 0, 1, 1, 2'b00, 0, 1, 0, 4'h0, 32'h0,        32'h00000012, 1, 0};
        vt[9]  = '{32'h00002003, 32'h0,        32'h80FF1234, 5'd7,  1, 0, 1, 1, 2'b00, 1, 1, 0, 4'h0, 32'h0,        32'h00000080, 1, 0};
        vt[10] = '{32'h00005000, 32'hCAFEF00D, 32'h0,        5'd0,  0, 1, 0, 0, 2'b10, 0, 1, 1, 4'hF, 32'hCAFEF00D, 32'h0,        0, 0};
        vt[11] = '{32'h00004003, 32'h0,        32'h0,        5'd12, 0, 0, 0, 1, 2'b10, 0, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0};
        vt[12] = '{32'h00006000, 32'h01020304, 32'hFFFFFFFF, 5'd0,  1, 1, 0, 0, 2'b11, 0, 1, 1, 4'hF, 32'h01020304, 32'h0,        0, 0};
        vt[13] = '{32'h00003003, 32'h000000A5, 32'h0,        5'd0,  0, 1, 0, 0, 2'b00, 0, 1, 1, 4'h8, 32'hA5A5A5A5, 32'h0,        0, 0};
        vt[14] = '{32'h00003000, 32'hFFFF1357, 32'h0,        5'd0,  0, 1, 0, 0, 2'b01, 0, 1, 1, 4'h3, 32'h13571357, 32'h0,        0, 0};

        // Reset held with an aligned load already presented
        reset          = 1'b0;
        aluResultado   = 32'h00001004;
        dadoEscrita    = 32'd0;
        regDestino     = 5'd8;
        memRead        = 1'b1;
        memWrite       = 1'b1;
        memToReg       = 1'b1;
        regWrite       = 1'b1;
        tamanho        = 2'b10;
        semSinal       = 1'b0;
        memDadoLeitura = 32'd0;
        memPronto      = 1'b0;
        #3;
        chk("rst_req", memReq, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_we", memWe, 1'b0);
        chk("rst_be", memByteEnable, 4'h0);
        chk("rst_rw", regWriteSaida, 1'b0);
        chk("rst_mo", memoriaSaida, 32'd0);
        chk("rst_to", excecaoTimeout, 1'b0);
        @(negedge clock);
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        reset    = 1'b1;

        // Zero-wait vector table
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            aluResultado   = vt[i].addr;
            dadoEscrita    = vt[i].wdata;
            memDadoLeitura = vt[i].rdata;
            regDestino     = vt[i].rd;
            memRead        = vt[i].rd_en;
            memWrite       = vt[i].wr_en;
            memToReg       = vt[i].m2r;
            regWrite       = vt[i].rw;
            tamanho        = vt[i].tam;
            semSinal       = vt[i].sem;
            memPronto      = 1'b1;
            #1;
            chk($sformatf("v%0d_req", i), memReq, vt[i].e_req);
            chk($sformatf("v%0d_we", i), memWe, vt[i].e_we);
            chk($sformatf("v%0d_be", i), memByteEnable, vt[i].e_be);
            chk($sformatf("v%0d_dw", i), memDadoEscrita, vt[i].e_dw);
            chk($sformatf("v%0d_addr", i), memEndereco, {vt[i].addr[31:2], 2'b00});
            chk($sformatf("v%0d_stall", i), stall, 1'b0);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_mo", i), memoriaSaida, vt[i].e_mo);
            chk($sformatf("v%0d_rw", i), regWriteSaida, vt[i].e_rw);
            chk($sformatf("v%0d_alin", i), excecaoAlinhamento, vt[i].e_alin);
            chk($sformatf("v%0d_ctrl", i), controle, vt[i].m2r);
            chk($sformatf("v%0d_rdd", i), regDestinoSaida, vt[i].rd);
            chk($sformatf("v%0d_alu", i), aluSaida, vt[i].addr);
            chk($sformatf("v%0d_to", i), excecaoTimeout, 1'b0);
        end

        // Wait-state loads, timeout, and memPronto on the limit cycle
        run_wait("sbyte", 32'h00002003, 32'h80FF1234, 2'b00, 1'b0, 3, 3, 32'hFFFFFF80, 1'b0);
        run_wait("ubyte", 32'h00002003, 32'h80FF1234, 2'b00, 1'b1, 3, 3, 32'h00000080, 1'b0);
        run_wait("tmo", 32'h00007000, 32'h13572468, 2'b10, 1'b0, -1, 16, 32'h0, 1'b1);
        run_wait("lim", 32'h00007000, 32'h13572468, 2'b10, 1'b0, 16, 16, 32'h13572468, 1'b0);

        // Reset while a word load sits in ESPERA
        @(negedge clock);
        aluResultado   = 32'h00001004;
        memDadoLeitura = 32'hDEADBEEF;
        regDestino     = 5'd8;
        memRead        = 1'b1;
        memWrite       = 1'b0;
        memToReg       = 1'b1;
        regWrite       = 1'b1;
        tamanho        = 2'b10;
        memPronto      = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        chk("mid_pre_stall", stall, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_req", memReq, 1'b0);
        chk("mid_stall", stall, 1'b0);
        chk("mid_rw", regWriteSaida, 1'b0);
        chk("mid_ctrl", controle, 1'b0);
        chk("mid_rdd", regDestinoSaida, 5'd0);
        chk("mid_alu", aluSaida, 32'd0);
        @(negedge clock);
        reset     = 1'b1;
        memPronto = 1'b1;
        #1;
        chk("post_req", memReq, 1'b1);
        chk("post_stall", stall, 1'b0);
        @(posedge clock);
        #1;
        chk("post_mo", memoriaSaida, 32'hDEADBEEF);
        chk("post_rw", regWriteSaida, 1'b1);
        chk("post_rdd", regDestinoSaida, 5'd8);
        @(negedge clock);
        memRead   = 1'b0;
        memPronto = 1'b0;
        regWrite  = 1'b0;
        // Full wait sequence from a freshly reset FSM
        run_wait("postwait", 32'h00001004, 32'hDEADBEEF, 2'b10, 1'b0, 2, 2, 32'hDEADBEEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
